// File: rtl/zion_riscv_isa_lib_add_sub_arbiter_if.sv
// Request/response bundle between the issue ports and the shared add/sub arbiter.
// Latency: none (wires only).
// Backpressure: carries per-requester accept and response ready.
interface zion_riscv_isa_lib_add_sub_arbiter_if #(
  parameter int RV64    = 0,
  parameter int NUM_REQ = 3,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  localparam int CPU_WIDTH = (RV64 != 0) ? 64 : 32;
  localparam int OP_W      = (RV64 != 0) ? 3 : 2;

  logic [NUM_REQ-1:0]           iReqVld;
  logic [NUM_REQ-1:0]           oReqRdy;
  logic [NUM_REQ*OP_W-1:0]      iReqOp;
  logic [NUM_REQ*CPU_WIDTH-1:0] iReqS1;
  logic [NUM_REQ*CPU_WIDTH-1:0] iReqS2;
  logic [NUM_REQ-1:0]           iReqUnsigned;
  logic                         oRspVld;
  logic                         iRspRdy;
  logic [ID_W-1:0]              oRspId;
  logic [CPU_WIDTH-1:0]         oRspRslt;
  logic                         oRspLt;
  logic                         oRspErr;

  // Requesters plus response consumer.
  modport master (
    output iReqVld, iReqOp, iReqS1, iReqS2, iReqUnsigned, iRspRdy,
    input  oReqRdy, oRspVld, oRspId, oRspRslt, oRspLt, oRspErr
  );

  // Arbiter side.
  modport slave (
    input  iReqVld, iReqOp, iReqS1, iReqS2, iReqUnsigned, iRspRdy,
    output oReqRdy, oRspVld, oRspId, oRspRslt, oRspLt, oRspErr
  );
endinterface

// File: rtl/zion_riscv_isa_lib_add_sub_arbiter.sv
// Round-robin arbiter sharing one add/sub datapath (result + less-than) among NUM_REQ requesters.
// Latency: 1 cycle from accept to response register.
// Backpressure: one-entry response stage; grants only when it is empty or draining this cycle.
module zion_riscv_isa_lib_add_sub_arbiter #(
  parameter int RV64    = 0,
  parameter int NUM_REQ = 3,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic clk,
  input  logic rst_n,
  zion_riscv_isa_lib_add_sub_arbiter_if.slave bus
);
  localparam int CPU_WIDTH = (RV64 != 0) ? 64 : 32;
  localparam int OP_W      = (RV64 != 0) ? 3 : 2;
  localparam int PW        = ID_W + 1;  // one spare bit so ptr + offset never overflows before wrap

  // Response stage and round-robin pointer
  logic                 r_vld;
  logic [ID_W-1:0]      r_id;
  logic [CPU_WIDTH-1:0] r_rslt;
  logic                 r_lt;
  logic                 r_err;
  logic [ID_W-1:0]      r_ptr;

  // Arbitration
  logic                 w_stg_rdy;
  logic                 w_any;
  logic                 w_xfer;
  logic [ID_W-1:0]      w_win;
  logic [ID_W-1:0]      w_ptr_nxt;
  logic [PW-1:0]        w_pos;
  logic [NUM_REQ-1:0]   w_req_rdy;

  // Datapath
  logic [OP_W-1:0]      w_op;
  logic [CPU_WIDTH-1:0] w_s1;
  logic [CPU_WIDTH-1:0] w_s2;
  logic                 w_uns;
  logic                 w_add;
  logic                 w_sub;
  logic [CPU_WIDTH-1:0] w_sum;
  logic [CPU_WIDTH-1:0] w_diff;
  logic [CPU_WIDTH-1:0] w_raw;
  logic [CPU_WIDTH-1:0] w_rslt;
  logic                 w_err;
  logic                 w_lt_raw;
  logic                 w_lt;

  // The stage can take a new result when empty or when its current one leaves this cycle.
  assign w_stg_rdy = !r_vld || bus.iRspRdy;

  // Find the first valid requester starting at the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_pos = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_pos = PW'(r_ptr) + PW'(k);
      if (w_pos >= PW'(NUM_REQ)) begin
        w_pos = w_pos - PW'(NUM_REQ);
      end
      if (!w_any && bus.iReqVld[w_pos[ID_W-1:0]]) begin
        w_any = 1'b1;
        w_win = w_pos[ID_W-1:0];
      end
    end
  end

  // Accept goes only to the winner, and never while reset is held.
  always_comb begin
    w_req_rdy = '0;
    if (rst_n && w_any && w_stg_rdy) begin
      w_req_rdy[w_win] = 1'b1;
    end
  end

  assign w_xfer      = w_any && w_stg_rdy;
  assign bus.oReqRdy = w_req_rdy;
  assign w_ptr_nxt   = (w_win == ID_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;

  // Winner's payload feeds the single shared adder.
  assign w_op   = bus.iReqOp[int'(w_win) * OP_W +: OP_W];
  assign w_s1   = bus.iReqS1[int'(w_win) * CPU_WIDTH +: CPU_WIDTH];
  assign w_s2   = bus.iReqS2[int'(w_win) * CPU_WIDTH +: CPU_WIDTH];
  assign w_uns  = bus.iReqUnsigned[w_win];
  assign w_add  = w_op[0];
  assign w_sub  = w_op[1];
  assign w_sum  = w_s1 + w_s2;
  assign w_diff = w_s1 + ~w_s2 + CPU_WIDTH'(1);

  // Select sum/difference; add+sub together is flagged and yields zero.
  always_comb begin
    w_raw = '0;
    w_err = 1'b0;
    case ({w_sub, w_add})
      2'b01:   w_raw = w_sum;
      2'b10:   w_raw = w_diff;
      2'b11:   w_err = 1'b1;
      default: w_raw = '0;
    endcase
  end

  // .W ops keep the low word and sign-extend it; only exists on the 64-bit datapath.
  if (RV64 != 0) begin : g_word
    assign w_rslt = w_op[OP_W-1] ? {{(CPU_WIDTH-32){w_raw[31]}}, w_raw[31:0]} : w_raw;
  end else begin : g_noword
    assign w_rslt = w_raw;
  end

  // Compare always uses the full-width difference, even for .W ops.
  assign w_lt_raw = (w_s1[CPU_WIDTH-1] ^ w_s2[CPU_WIDTH-1])
                  ? (w_uns ? w_s2[CPU_WIDTH-1] : w_s1[CPU_WIDTH-1])
                  : w_diff[CPU_WIDTH-1];
  assign w_lt     = w_sub && !w_add && w_lt_raw;

  // Load response on a transfer, drain it when consumed, advance the pointer past the winner.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld  <= 1'b0;
      r_id   <= '0;
      r_rslt <= '0;
      r_lt   <= 1'b0;
      r_err  <= 1'b0;
      r_ptr  <= '0;
    end else if (w_xfer) begin
      r_vld  <= 1'b1;
      r_id   <= w_win;
      r_rslt <= w_rslt;
      r_lt   <= w_lt;
      r_err  <= w_err;
      r_ptr  <= w_ptr_nxt;
    end else if (bus.iRspRdy) begin
      r_vld  <= 1'b0;
    end
  end

  assign bus.oRspVld  = r_vld;
  assign bus.oRspId   = r_id;
  assign bus.oRspRslt = r_rslt;
  assign bus.oRspLt   = r_lt;
  assign bus.oRspErr  = r_err;

  // At most one requester is accepted per cycle.
  a_rdy_onehot: assert property (@(posedge clk) $onehot0(w_req_rdy));

  // A stalled response must not change under the consumer.
  a_rsp_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (r_vld && !bus.iRspRdy) |=> $stable({r_vld, r_id, r_rslt, r_lt, r_err}));

endmodule

// File: tb/tb_zion_riscv_isa_lib_add_sub_arbiter.sv
// Bench for the shared add/sub arbiter: RV32 table + sequences with a scoreboard, RV64 directed ops.
// Latency: expects responses one cycle after accept.
// Backpressure: exercises stalled response stage and mid-operation reset.
module tb_zion_riscv_isa_lib_add_sub_arbiter;

  typedef struct {
    int          req;
    logic [1:0]  op;
    logic [31:0] s1;
    logic [31:0] s2;
    logic        uns;
    logic [31:0] rslt;
    logic        lt;
    logic        err;
  } vec_t;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] rslt;
    logic        lt;
    logic        err;
  } exp_t;

  localparam int NV = 12;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  vec_t vecs [NV];
  exp_t exp_tab [3];
  exp_t sb [$];
  int   rsp_log [$];
  logic m_vld;
  int   m_ptr;

  zion_riscv_isa_lib_add_sub_arbiter_if #(.RV64(0), .NUM_REQ(3)) bus32 ();
  zion_riscv_isa_lib_add_sub_arbiter_if #(.RV64(1), .NUM_REQ(3)) bus64 ();

  zion_riscv_isa_lib_add_sub_arbiter #(.RV64(0), .NUM_REQ(3)) u_dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus32)
  );

  zion_riscv_isa_lib_add_sub_arbiter #(.RV64(1), .NUM_REQ(3)) u_dut64 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic set_req(int i, logic [1:0] op, logic [31:0] s1, logic [31:0] s2, logic uns,
                         logic [31:0] er, logic el, logic ee);
    bus32.iReqOp[i*2 +: 2]  = op;
    bus32.iReqS1[i*32 +: 32] = s1;
    bus32.iReqS2[i*32 +: 32] = s2;
    bus32.iReqUnsigned[i]    = uns;
    exp_tab[i] = '{id: 2'(i), rslt: er, lt: el, err: ee};
  endtask

  // One RV32 cycle: called at a falling edge with inputs already driven.
  task automatic cyc();
    logic       stg;
    logic       any;
    int         win;
    int         idx;
    logic [2:0] exp_rdy;
    exp_t       e;
    #1;
    stg = !m_vld || bus32.iRspRdy;
    any = 1'b0;
    win = 0;
    for (int k = 0; k < 3; k++) begin
      idx = (m_ptr + k) % 3;
      if (!any && bus32.iReqVld[idx]) begin
        any = 1'b1;
        win = idx;
      end
    end
    exp_rdy = (rst_n && any && stg) ? 3'(1 << win) : 3'b000;
    chk("req_rdy", 64'(bus32.oReqRdy), 64'(exp_rdy));
    if (m_vld) begin
      chk("rsp_vld", 64'(bus32.oRspVld), 64'd1);
      if (sb.size() == 0) begin
        chk("sb_underflow", 64'(sb.size()), 64'd1);
      end else begin
        e = sb[0];
        chk("rsp_id",   64'(bus32.oRspId),   64'(e.id));
        chk("rsp_rslt", 64'(bus32.oRspRslt), 64'(e.rslt));
        chk("rsp_lt",   64'(bus32.oRspLt),   64'(e.lt));
        chk("rsp_err",  64'(bus32.oRspErr),  64'(e.err));
        if (bus32.iRspRdy) begin
          rsp_log.push_back(int'(bus32.oRspId));
          void'(sb.pop_front());
        end
      end
    end else begin
      chk("rsp_idle", 64'(bus32.oRspVld), 64'd0);
    end
    if (!rst_n) begin
      m_vld = 1'b0;
      m_ptr = 0;
      sb.delete();
    end else if (exp_rdy != 3'b000) begin
      sb.push_back(exp_tab[win]);
      m_ptr = (win + 1) % 3;
      m_vld = 1'b1;
    end else if (bus32.iRspRdy) begin
      m_vld = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic check_log(string name, int exp_ids [$]);
    chk({name, "_len"}, 64'(rsp_log.size()), 64'(exp_ids.size()));
    for (int k = 0; k < exp_ids.size() && k < rsp_log.size(); k++) begin
      chk(name, 64'(rsp_log[k]), 64'(exp_ids[k]));
    end
  endtask

  task automatic check_zero32(string name);
    chk({name, "_vld"},  64'(bus32.oRspVld),  64'd0);
    chk({name, "_id"},   64'(bus32.oRspId),   64'd0);
    chk({name, "_rslt"}, 64'(bus32.oRspRslt), 64'd0);
    chk({name, "_lt"},   64'(bus32.oRspLt),   64'd0);
    chk({name, "_err"},  64'(bus32.oRspErr),  64'd0);
  endtask

  // RV64 single request on requester 0, consumer always ready.
  task automatic run64(string name, logic [2:0] op, logic [63:0] s1, logic [63:0] s2, logic uns,
                       logic [63:0] er, logic el, logic ee);
    bus64.iReqVld         = 3'b001;
    bus64.iReqOp[2:0]     = op;
    bus64.iReqS1[63:0]    = s1;
    bus64.iReqS2[63:0]    = s2;
    bus64.iReqUnsigned[0] = uns;
    #1;
    chk({name, "_rdy"}, 64'(bus64.oReqRdy), 64'd1);
    @(negedge clk);
    bus64.iReqVld = 3'b000;
    #1;
    chk({name, "_vld"},  64'(bus64.oRspVld), 64'd1);
    chk({name, "_rslt"}, bus64.oRspRslt,     er);
    chk({name, "_lt"},   64'(bus64.oRspLt),  64'(el));
    chk({name, "_err"},  64'(bus64.oRspErr), 64'(ee));
    @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    m_vld = 1'b0;
    m_ptr = 0;

    vecs[0]  = '{1, 2'b01, 32'h7FFF_FFFF, 32'h1,         1'b0, 32'h8000_0000, 1'b0, 1'b0};
    vecs[1]  = '{0, 2'b10, 32'hFFFF_FFFF, 32'h1,         1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0};
    vecs[2]  = '{2, 2'b10, 32'hFFFF_FFFF, 32'h1,         1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[3]  = '{1, 2'b11, 32'h5,         32'h3,         1'b0, 32'h0,         1'b0, 1'b1};
    vecs[4]  = '{0, 2'b00, 32'h5,         32'h3,         1'b0, 32'h0,         1'b0, 1'b0};
    vecs[5]  = '{2, 2'b10, 32'h3,         32'h5,         1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0};
    vecs[6]  = '{1, 2'b10, 32'h3,         32'h5,         1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0};
    vecs[7]  = '{0, 2'b10, 32'h8000_0000, 32'h1,         1'b0, 32'h7FFF_FFFF, 1'b1, 1'b0};
    vecs[8]  = '{2, 2'b10, 32'h8000_0000, 32'h1,         1'b1, 32'h7FFF_FFFF, 1'b0, 1'b0};
    vecs[9]  = '{0, 2'b01, 32'hFFFF_FFFF, 32'h1,         1'b0, 32'h0,         1'b0, 1'b0};
    vecs[10] = '{1, 2'b01, 32'h3,         32'h5,         1'b0, 32'h8,         1'b0, 1'b0};
    vecs[11] = '{2, 2'b10, 32'h5,         32'h5,         1'b0, 32'h0,         1'b0, 1'b0};

    rst_n = 1'b0;
    bus32.iReqVld = 3'b101;
    bus32.iReqOp = '0;
    bus32.iReqS1 = '0;
    bus32.iReqS2 = '0;
    bus32.iReqUnsigned = '0;
    bus32.iRspRdy = 1'b0;
    bus64.iReqVld = '0;
    bus64.iReqOp = '0;
    bus64.iReqS1 = '0;
    bus64.iReqS2 = '0;
    bus64.iReqUnsigned = '0;
    bus64.iRspRdy = 1'b1;

    // Reset state, with requests present
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_req_rdy", 64'(bus32.oReqRdy), 64'd0);
    check_zero32("rst");
    chk("rst_vld64", 64'(bus64.oRspVld), 64'd0);
    bus32.iReqVld = 3'b000;
    @(negedge clk);
    rst_n = 1'b1;
    bus32.iRspRdy = 1'b1;

    // Table vectors, one requester per cycle, back-to-back
    for (int v = 0; v < NV; v++) begin
      set_req(vecs[v].req, vecs[v].op, vecs[v].s1, vecs[v].s2, vecs[v].uns,
              vecs[v].rslt, vecs[v].lt, vecs[v].err);
      bus32.iReqVld = 3'(1 << vecs[v].req);
      cyc();
    end
    bus32.iReqVld = 3'b000;
    cyc();
    cyc();

    // Round-robin with all three requesters pending
    rsp_log.delete();
    for (int i = 0; i < 3; i++) begin
      set_req(i, 2'b01, 32'(i * 16), 32'h1, 1'b0, 32'(i * 16 + 1), 1'b0, 1'b0);
    end
    bus32.iReqVld = 3'b111;
    repeat (6) cyc();
    bus32.iReqVld = 3'b000;
    cyc();
    cyc();
    check_log("rr_order", '{0, 1, 2, 0, 1, 2});

    // Backpressure: stall with req0 and req2 pending, then release
    rsp_log.delete();
    bus32.iRspRdy = 1'b0;
    bus32.iReqVld = 3'b101;
    repeat (3) cyc();
    bus32.iRspRdy = 1'b1;
    cyc();
    bus32.iReqVld = 3'b011;
    cyc();
    bus32.iReqVld = 3'b010;
    cyc();
    bus32.iReqVld = 3'b000;
    cyc();
    cyc();
    check_log("bp_order", '{0, 2, 0, 1});

    // Reset while a response is pending and the pointer is off zero
    rsp_log.delete();
    bus32.iRspRdy = 1'b0;
    bus32.iReqVld = 3'b001;
    cyc();
    bus32.iReqVld = 3'b101;
    cyc();
    rst_n = 1'b0;
    cyc();
    #1;
    check_zero32("mid_rst");
    rst_n = 1'b1;
    bus32.iRspRdy = 1'b1;
    cyc();
    bus32.iReqVld = 3'b100;
    cyc();
    bus32.iReqVld = 3'b000;
    cyc();
    cyc();
    check_log("post_rst_order", '{0, 2});

    // RV64 datapath
    run64("w_sub",   3'b110, 64'h0000_0001_0000_0000, 64'h1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    run64("sub64",   3'b010, 64'h0000_0001_0000_0000, 64'h1, 1'b0, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0);
    run64("w_add",   3'b101, 64'h0000_0000_7FFF_FFFF, 64'h1, 1'b0, 64'hFFFF_FFFF_8000_0000, 1'b0, 1'b0);
    run64("w_sublt", 3'b110, 64'h1,                   64'h2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    run64("u_sub64", 3'b010, 64'h0,                   64'h1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    run64("ill64",   3'b011, 64'h5,                   64'h3, 1'b0, 64'h0,                   1'b0, 1'b1);

    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
